// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared processor constants and types for instruction fetch
package instr_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h00000013;
    localparam logic [31:0] EBREAK_INSTR = 32'h00100073;
    localparam logic [31:0] RESET_OUT_PC = 32'h00000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_OUT_PC, instr: NOP_INSTR};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - parameterised synchronous FIFO with flush and occupancy count
module fetch_queue #(
    parameter int               WIDTH      = 64,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       count
);

    localparam int            PW   = (DEPTH > 2) ? 2 : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [2:0]    FULL = 3'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_rd;
    logic             do_wr;

    assign rd_valid = (count != 3'd0);
    assign rd_data  = mem[rd_ptr];
    assign do_rd    = rd_ready && rd_valid;
    // A write into a full queue is only legal when the head leaves in the same cycle.
    assign do_wr    = wr_valid && ((count != FULL) || do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_DATA;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencing, redirect/halt control and fetch queue front end
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err
);

    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

    state_t       state;
    logic [31:0]  pc;
    logic [2:0]   count;
    logic         q_valid;
    logic         deq;
    logic         fetch;
    fetch_entry_t head;
    fetch_entry_t fetch_entry;

    // Redirect owns the cycle: it blocks both ends of the queue while flushing it.
    assign deq         = q_valid && out_ready && !redirect_valid;
    assign fetch       = (state == ST_RUN) && !redirect_valid && ((count < DEPTH_CNT) || deq);
    assign fetch_entry = '{pc: pc, instr: imem_rdata};

    assign imem_addr = pc;
    assign out_valid = q_valid;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    fetch_queue #(
        .WIDTH      ($bits(fetch_entry_t)),
        .DEPTH      (DEPTH),
        .RESET_DATA (RESET_ENTRY)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .wr_valid (fetch),
        .wr_data  (fetch_entry),
        .rd_ready (deq),
        .rd_valid (q_valid),
        .rd_data  (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= ST_IDLE;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc     <= word_align(redirect_pc);
                state  <= fetch_en ? ST_RUN : ST_IDLE;
                halted <= 1'b0;
            end else begin
                if (fetch) begin
                    pc <= pc + 32'd4;
                end
                case (state)
                    ST_IDLE: begin
                        if (fetch_en) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (fetch && (imem_rdata == EBREAK_INSTR)) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else if (!fetch_en) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
